// File: rtl/sr595_pkg.sv
// Shared definitions for the 74x595 chain driver: FSM state encoding and frame timing.
package sr595_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        CLOCK,
        LATCH
    } sr595_state_e;

    // Cycles ready stays low after a transfer: WIDTH SETUP/CLOCK pairs plus one LATCH phase.
    function automatic int unsigned frame_busy_cycles(input int unsigned width,
                                                      input int unsigned div);
        return (2 * width + 1) * div;
    endfunction

endpackage

// File: rtl/sr595_phase_tick.sv
// Phase timer for the 74x595 driver: counts DIV cycles per serial phase and
// strobes last_o on the final cycle of each phase.
module sr595_phase_tick #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic last_o
);

    localparam int unsigned  CW       = $clog2(DIV + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Every non-IDLE state change happens on a last cycle, so wrapping there
    // restarts the count for the next state; IDLE holds it at zero.
    always_comb begin
        if (restart_i || (cnt_q == LAST_CNT)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the next value
    // is computed in always_comb so this block is a plain register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/sr595_driver.sv
// Serialises a WIDTH-bit word MSB first into a chain of 74x595 shift registers,
// then pulses RCLK to latch it; all pin outputs come straight from flops.
module sr595_driver
    import sr595_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             ser,
    output logic             srclk,
    output logic             rclk,
    output logic             oe_n
);

    localparam int unsigned    BCW       = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] BITS_FULL = BCW'(WIDTH);
    localparam logic [BCW-1:0] BITS_LAST = BCW'(1);

    sr595_state_e     state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_shl;
    logic [BCW-1:0]   bits_q;
    logic             ser_q;
    logic             srclk_q;
    logic             rclk_q;
    logic             oe_n_q;
    logic             phase_last;

    sr595_phase_tick #(
        .DIV(DIV)
    ) u_phase_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(state_q == IDLE),
        .last_o   (phase_last)
    );

    assign sreg_shl = sreg_q << 1;

    // NOTE: the asynchronous reset clears every pin flop, so a reset mid-frame
    // drops SRCLK/RCLK/SER at once and blanks the outputs without a latch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bits_q  <= '0;
            ser_q   <= 1'b0;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
            oe_n_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid) begin
                        sreg_q  <= data;
                        bits_q  <= BITS_FULL;
                        ser_q   <= data[WIDTH-1];
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_last) begin
                        srclk_q <= 1'b1;
                        state_q <= CLOCK;
                    end
                end
                CLOCK: begin
                    if (phase_last) begin
                        sreg_q  <= sreg_shl;
                        bits_q  <= bits_q - 1'b1;
                        srclk_q <= 1'b0;
                        if (bits_q == BITS_LAST) begin
                            rclk_q  <= 1'b1;
                            state_q <= LATCH;
                        end else begin
                            // Next bit is presented together with the SRCLK fall.
                            ser_q   <= sreg_shl[WIDTH-1];
                            state_q <= SETUP;
                        end
                    end
                end
                LATCH: begin
                    if (phase_last) begin
                        rclk_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign ser   = ser_q;
    assign srclk = srclk_q;
    assign rclk  = rclk_q;
    assign oe_n  = oe_n_q;

endmodule

// File: tb/tb_sr595_driver.sv
// Bench for sr595_driver: three configurations, each observed by a 74x595
// chain model plus phase/busy-length monitors sampled on the falling clock edge.
module tb_sr595_driver;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  vld, rdy, sd, sk, rk, oen;
    logic [7:0]  a_data, s_data;
    logic [15:0] w_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    sr595_driver #(.WIDTH(8), .DIV(2)) u_a (
        .clk(clk), .rst_n(rst_n), .data(a_data), .valid(vld[0]), .ready(rdy[0]),
        .ser(sd[0]), .srclk(sk[0]), .rclk(rk[0]), .oe_n(oen[0]));
    sr595_driver #(.WIDTH(16), .DIV(1)) u_w (
        .clk(clk), .rst_n(rst_n), .data(w_data), .valid(vld[1]), .ready(rdy[1]),
        .ser(sd[1]), .srclk(sk[1]), .rclk(rk[1]), .oe_n(oen[1]));
    sr595_driver #(.WIDTH(8), .DIV(3)) u_s (
        .clk(clk), .rst_n(rst_n), .data(s_data), .valid(vld[2]), .ready(rdy[2]),
        .ser(sd[2]), .srclk(sk[2]), .rclk(rk[2]), .oe_n(oen[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int wid(input int i);
        return (i == 1) ? 16 : 8;
    endfunction

    function automatic int dv(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
    endfunction

    function automatic int exp_busy(input int i);
        return (2 * wid(i) + 1) * dv(i);
    endfunction

    function automatic logic [15:0] wmask(input int i);
        return 16'((32'd1 << wid(i)) - 1);
    endfunction

    // Monitor state: chain model of the 595s plus phase-length bookkeeping.
    logic        p_sk[NI], p_rk[NI], p_sd[NI];
    logic [15:0] chain[NI], latched[NI];
    int latch_cnt[NI], frames[NI], busy_run[NI], last_busy[NI];
    int run_len[NI], run_cnt[NI], run_bad[NI], rk_run[NI], last_rk_w[NI];
    int hi_chg[NI], sk_rises[NI];

    task automatic end_run(input int i);
        run_cnt[i]++;
        if (run_len[i] != dv(i)) run_bad[i]++;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                busy_run[i] = 0;
                run_len[i]  = 0;
                rk_run[i]   = 0;
            end else begin
                if (!rdy[i]) begin
                    if (busy_run[i] == 0) run_len[i] = 1;
                    else if (sk[i] == p_sk[i]) run_len[i]++;
                    else begin
                        end_run(i);
                        run_len[i] = 1;
                    end
                    busy_run[i]++;
                end else if (busy_run[i] != 0) begin
                    end_run(i);
                    last_busy[i] = busy_run[i];
                    busy_run[i]  = 0;
                    frames[i]++;
                end
                if (sk[i] && !p_sk[i]) begin
                    chain[i] = {chain[i][14:0], sd[i]};
                    sk_rises[i]++;
                end
                if (sk[i] && p_sk[i] && (sd[i] != p_sd[i])) hi_chg[i]++;
                if (rk[i]) rk_run[i]++;
                if (rk[i] && !p_rk[i]) begin
                    latched[i] = chain[i] & wmask(i);
                    latch_cnt[i]++;
                end
                if (!rk[i] && p_rk[i]) begin
                    last_rk_w[i] = rk_run[i];
                    rk_run[i]    = 0;
                end
            end
            p_sk[i] = sk[i];
            p_rk[i] = rk[i];
            p_sd[i] = sd[i];
        end
    end

    task automatic set_in(input int i, input logic v, input logic [15:0] d);
        case (i)
            0:       a_data = d[7:0];
            1:       w_data = d;
            default: s_data = d[7:0];
        endcase
        vld[i] = v;
    endtask

    // Offers d on instance i and returns just after the accepting edge.
    task automatic xfer(input int i, input logic [15:0] d, output int acc);
        bit ok = 0;
        acc = -1;
        set_in(i, 1'b1, d);
        for (int n = 0; n < 400 && !ok; n++) begin
            if (rdy[i] === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cyc;
                ok  = 1;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL xfer_timeout[%0d]: ready never seen, data %h", i, d);
        end
    endtask

    task automatic wait_frames(input int i, input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frames[i] < target && n < 3000);
        checks++;
        if (frames[i] < target) begin
            failures++;
            $display("FAIL frame_timeout[%0d]: frames %0d expected %0d", i, frames[i], target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vld = '0;
        a_data = '0;
        w_data = '0;
        s_data = '0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({sd[i], sk[i], rk[i], oen[i]} !== 4'b0001) begin
                    failures++;
                    $display("FAIL reset_outputs[%0d]: ser/srclk/rclk/oe_n got %b expected 0001",
                             i, {sd[i], sk[i], rk[i], oen[i]});
                end
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdy !== 3'b111) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 111", rdy);
        end
    endtask

    task automatic test_single_a5();
        int acc, f0, l0, rc0, rb0, s0, n;
        f0 = frames[0]; l0 = latch_cnt[0]; rc0 = run_cnt[0]; rb0 = run_bad[0]; s0 = sk_rises[0];
        xfer(0, 16'h00A5, acc);
        set_in(0, 1'b0, 16'h0);
        checks++;
        if (oen[0] !== 1'b1) begin
            failures++;
            $display("FAIL a5_oe_before_latch: got %b expected 1", oen[0]);
        end
        n = 0;
        while (rk[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({rk[0], oen[0]} !== 2'b11) begin
            failures++;
            $display("FAIL a5_oe_during_latch: rclk/oe_n got %b expected 11", {rk[0], oen[0]});
        end
        wait_frames(0, f0 + 1);
        checks++;
        if (latched[0] !== 16'h00A5) begin
            failures++;
            $display("FAIL a5_latched: got %h expected 00a5", latched[0]);
        end
        checks++;
        if (last_busy[0] != 34) begin
            failures++;
            $display("FAIL a5_busy_len: got %0d expected 34", last_busy[0]);
        end
        checks++;
        if (last_rk_w[0] != 2 || latch_cnt[0] != l0 + 1) begin
            failures++;
            $display("FAIL a5_rclk_pulse: width %0d count %0d expected width 2 count %0d",
                     last_rk_w[0], latch_cnt[0] - l0, 1);
        end
        checks++;
        if (sk_rises[0] - s0 != 8) begin
            failures++;
            $display("FAIL a5_srclk_edges: got %0d expected 8", sk_rises[0] - s0);
        end
        checks++;
        if (run_cnt[0] - rc0 != 17 || run_bad[0] != rb0) begin
            failures++;
            $display("FAIL a5_phases: runs %0d bad %0d expected runs 17 bad 0",
                     run_cnt[0] - rc0, run_bad[0] - rb0);
        end
        checks++;
        if (oen[0] !== 1'b0) begin
            failures++;
            $display("FAIL a5_oe_after_latch: got %b expected 0", oen[0]);
        end
    endtask

    // Random words on instance i; each frame checked for content, timing and phase lengths.
    task automatic test_random_frames(input int i, input int nf, input logic [15:0] first);
        int acc, f0, l0, rc0, rb0;
        logic [15:0] d;
        for (int k = 0; k < nf; k++) begin
            d = (k == 0) ? first : (16'($urandom) & wmask(i));
            f0 = frames[i]; l0 = latch_cnt[i]; rc0 = run_cnt[i]; rb0 = run_bad[i];
            xfer(i, d, acc);
            set_in(i, 1'b0, 16'h0);
            wait_frames(i, f0 + 1);
            checks++;
            if (latched[i] !== d) begin
                failures++;
                $display("FAIL rand_latched[%0d]: got %h expected %h", i, latched[i], d);
            end
            checks++;
            if (last_busy[i] != exp_busy(i)) begin
                failures++;
                $display("FAIL rand_busy_len[%0d]: got %0d expected %0d", i, last_busy[i], exp_busy(i));
            end
            checks++;
            if (run_cnt[i] - rc0 != 2 * wid(i) + 1 || run_bad[i] != rb0) begin
                failures++;
                $display("FAIL rand_phases[%0d]: runs %0d bad %0d expected runs %0d bad 0",
                         i, run_cnt[i] - rc0, run_bad[i] - rb0, 2 * wid(i) + 1);
            end
            checks++;
            if (last_rk_w[i] != dv(i) || latch_cnt[i] != l0 + 1) begin
                failures++;
                $display("FAIL rand_rclk[%0d]: width %0d count %0d expected width %0d count 1",
                         i, last_rk_w[i], latch_cnt[i] - l0, dv(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2, f0, l0;
        f0 = frames[0]; l0 = latch_cnt[0];
        xfer(0, 16'h0001, c1);
        xfer(0, 16'h00FF, c2);
        checks++;
        if (c2 - c1 != 35) begin
            failures++;
            $display("FAIL b2b_gap: accept spacing got %0d expected 35", c2 - c1);
        end
        checks++;
        if (latched[0] !== 16'h0001) begin
            failures++;
            $display("FAIL b2b_first: got %h expected 0001", latched[0]);
        end
        set_in(0, 1'b0, 16'h0);
        wait_frames(0, f0 + 2);
        checks++;
        if (latched[0] !== 16'h00FF || latch_cnt[0] != l0 + 2) begin
            failures++;
            $display("FAIL b2b_second: got %h count %0d expected 00ff count 2",
                     latched[0], latch_cnt[0] - l0);
        end
    endtask

    task automatic test_busy_ignore();
        int acc, f0, l0, n;
        logic [15:0] d;
        for (int k = 0; k < 3; k++) begin
            d = 16'($urandom_range(0, 255));
            f0 = frames[0]; l0 = latch_cnt[0];
            xfer(0, d, acc);
            n = 0;
            while (n < 200) begin
                @(negedge clk);
                n++;
                if (rdy[0] === 1'b1) break;
                set_in(0, 1'($urandom), 16'($urandom));
            end
            set_in(0, 1'b0, 16'h0);
            wait_frames(0, f0 + 1);
            repeat (4) @(negedge clk);
            checks++;
            if (latched[0] !== d || latch_cnt[0] != l0 + 1) begin
                failures++;
                $display("FAIL busy_ignore_latched: got %h count %0d expected %h count 1",
                         latched[0], latch_cnt[0] - l0, d);
            end
            checks++;
            if (rdy[0] !== 1'b1 || frames[0] != f0 + 1) begin
                failures++;
                $display("FAIL busy_ignore_no_extra: ready %b frames %0d expected ready 1 frames 1",
                         rdy[0], frames[0] - f0);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int acc, s0, l0, f0, n, c_rel;
        s0 = sk_rises[0]; l0 = latch_cnt[0];
        xfer(0, 16'h00B4, acc);
        set_in(0, 1'b0, 16'h0);
        n = 0;
        while (sk_rises[0] < s0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({sd[0], sk[0], rk[0], oen[0]} !== 4'b1100) begin
            failures++;
            $display("FAIL midreset_pre: ser/srclk/rclk/oe_n got %b expected 1100",
                     {sd[0], sk[0], rk[0], oen[0]});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({sd[0], sk[0], rk[0], oen[0]} !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_async: ser/srclk/rclk/oe_n got %b expected 0001",
                     {sd[0], sk[0], rk[0], oen[0]});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c_rel = cyc;
        f0 = frames[0];
        checks++;
        if (latch_cnt[0] != l0 || oen[0] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_no_latch: latches %0d oe_n %b expected 0 and 1",
                     latch_cnt[0] - l0, oen[0]);
        end
        xfer(0, 16'h003C, acc);
        set_in(0, 1'b0, 16'h0);
        checks++;
        if (acc != c_rel + 1) begin
            failures++;
            $display("FAIL midreset_first_edge: accepted at %0d expected %0d", acc, c_rel + 1);
        end
        wait_frames(0, f0 + 1);
        checks++;
        if (latched[0] !== 16'h003C || latch_cnt[0] != l0 + 1 || oen[0] !== 1'b0) begin
            failures++;
            $display("FAIL midreset_next_frame: got %h count %0d oe_n %b expected 003c count 1 oe_n 0",
                     latched[0], latch_cnt[0] - l0, oen[0]);
        end
    endtask

    task automatic test_ser_stable();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (hi_chg[i] != 0) begin
                failures++;
                $display("FAIL ser_stable[%0d]: ser changed %0d times while srclk high expected 0",
                         i, hi_chg[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        vld = '0;
        #2;
        test_reset();
        test_single_a5();
        test_random_frames(1, 4, 16'h8001);
        test_back_to_back();
        test_busy_ignore();
        test_reset_midframe();
        test_random_frames(2, 4, 16'h00C6);
        test_random_frames(0, 3, 16'h005A);
        test_ser_stable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr595_driver.md
SR595_DRIVER -- requirements
Module: sr595_driver

Interface
REQ-001 Parameter WIDTH, default 8: number of bits shifted per frame (one 74x595 per 8 bits); SHALL be >= 1.
REQ-002 Parameter DIV, default 2: system-clock cycles per serial phase; SHALL be >= 1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 data  input  WIDTH  parallel word to transmit; bit WIDTH-1 lands in the chain's far-end QH.
REQ-006 valid  input  1  data is valid and offered for transfer.
REQ-007 ready  output  1  block accepts a word this cycle.
REQ-008 ser  output  1  serial data to the first 74x595's SER pin.
REQ-009 srclk  output  1  shift clock to every SRCLK pin.
REQ-010 rclk  output  1  storage-register latch clock to every RCLK pin.
REQ-011 oe_n  output  1  output enable to every OE_n pin, active low.
REQ-012 One clock; reset is asynchronous and active-low.

Function
REQ-013 A transfer SHALL occur on a rising edge where valid=1 and ready=1; data is captured into an internal shift register on that edge.
REQ-014 ready SHALL be 1 only in state IDLE; data is ignored while ready=0.
REQ-015 States SHALL be IDLE, SETUP, CLOCK and LATCH; each non-IDLE state lasts exactly DIV cycles.
REQ-016 IDLE -> SETUP on transfer; SETUP -> CLOCK; CLOCK -> SETUP while bits remain; CLOCK -> LATCH after the WIDTH-th bit; LATCH -> IDLE.
REQ-017 In SETUP, srclk=0, rclk=0 and ser=shift-register MSB; ser SHALL be stable for the whole SETUP and CLOCK pair.
REQ-018 In CLOCK, srclk=1; on the final cycle of CLOCK, the shift register SHALL shift left by one and the bit counter SHALL decrement.
REQ-019 Bits SHALL be sent MSB first: data[WIDTH-1] first, data[0] last.
REQ-020 In LATCH, srclk=0 and rclk=1; rclk SHALL be 0 in every other state.
REQ-021 ready SHALL be 0 for exactly (2*WIDTH+1)*DIV cycles after a transfer; with defaults, 34 cycles.
REQ-022 A new transfer is allowed on the first cycle ready returns to 1; back-to-back frames SHALL therefore have no extra idle cycle.
REQ-023 oe_n SHALL stay 1 from reset until the end of the first LATCH, then 0 until the next reset.
REQ-024 In IDLE, ser SHALL hold its last value; srclk and rclk SHALL be 0.
REQ-025 The bit counter SHALL be $clog2(WIDTH+1) bits wide; the phase counter SHALL be $clog2(DIV+1) bits wide; neither may wrap during a frame.
REQ-026 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs, apart from ready being decoded from state.

Reset
REQ-027 While rst_n=0: state=IDLE, ready=1 after release, ser=0, srclk=0, rclk=0, oe_n=1, and shift register and counters are 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately and asynchronously; no rclk pulse is issued, and the partial frame is lost.
REQ-029 The first transfer is allowed on the first rising edge after rst_n deasserts.

Structure
REQ-030 Package sr595_pkg SHALL hold the state enum (IDLE, SETUP, CLOCK, LATCH) and a localparam function computing the frame busy length (2*WIDTH+1)*DIV.
REQ-031 One sub-module, sr595_phase_tick, SHALL provide the DIV-cycle phase counter: it restarts on state change and emits a last-cycle strobe.
REQ-032 No other sub-modules are needed; the FSM, shift register and bit counter live in sr595_driver.

Verification
REQ-033 Defaults, data=8'hA5 with a single transfer -> ser bits 1,0,1,0,0,1,0,1 sampled at 8 srclk rising edges; one rclk pulse 2 cycles wide; ready low 34 cycles; oe_n falls at the end of LATCH.
REQ-034 WIDTH=16, DIV=1, data=16'h8001, with a 595-chain model on the bench -> chain outputs 16'h8001 after rclk; ready low 33 cycles.
REQ-035 valid held high with data 8'h01 then 8'hFF -> second transfer on the first ready=1 cycle; model latches 8'h01 then 8'hFF with no gap cycle.
REQ-036 valid toggled and data changed while ready=0 -> no effect on ser; only the captured word is latched.
REQ-037 rst_n pulsed low after the 3rd srclk of a frame -> srclk, rclk and ser go to 0 and oe_n to 1 asynchronously; no rclk pulse occurs; the next frame, 8'h3C, latches correctly.
REQ-038 DIV=3 -> every srclk high and low phase measures exactly 3 cycles, and ser never changes while srclk=1.
